// File: rtl/regfile_scoreboard.sv
// Pipeline register file with two bypassed read ports, a debug port and a
// per-register write-pending scoreboard that flags hazards to decode.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  input  logic [ADDR_WIDTH-1:0] read_address_2,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic                  hazard_1,
  output logic                  hazard_2,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_address,
  input  logic [ADDR_WIDTH-1:0] read_address_debug,
  output logic [DATA_WIDTH-1:0] data_out_debug,
  output logic                  busy_out_debug
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  logic                  write_hit;
  logic [DATA_WIDTH-1:0] rd_1;
  logic [DATA_WIDTH-1:0] rd_2;
  logic [DATA_WIDTH-1:0] rd_debug;

  assign write_hit = write_enable && (write_address != '0);

  // Bypass: a same-cycle write to the read address supplies the data directly.
  assign rd_1 = (read_address_1 == '0) ? '0 :
                (write_enable && write_address == read_address_1) ? write_data_in :
                regs[read_address_1];
  assign rd_2 = (read_address_2 == '0) ? '0 :
                (write_enable && write_address == read_address_2) ? write_data_in :
                regs[read_address_2];
  assign rd_debug = (read_address_debug == '0) ? '0 :
                    (write_enable && write_address == read_address_debug) ? write_data_in :
                    regs[read_address_debug];

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (write_enable) busy_next[write_address] = 1'b0;
    if (issue_valid)  busy_next[issue_address] = 1'b1;  // set wins over clear
    busy_next[0] = 1'b0;
  end

  assign hazard_1 = busy[read_address_1] && (read_address_1 != '0) &&
                    !(write_enable && write_address == read_address_1);
  assign hazard_2 = busy[read_address_2] && (read_address_2 != '0) &&
                    !(write_enable && write_address == read_address_2);

  // NOTE: the array is reset because the register file must read back zero after reset;
  // that rules out RAM inference, which is acceptable at these sizes.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy           <= '0;
      data_out_1     <= '0;
      data_out_2     <= '0;
      data_out_debug <= '0;
      busy_out_debug <= 1'b0;
    end else begin
      if (write_hit) regs[write_address] <= write_data_in;
      busy           <= busy_next;
      data_out_1     <= rd_1;
      data_out_2     <= rd_2;
      data_out_debug <= rd_debug;
      busy_out_debug <= busy_next[read_address_debug];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (32x32 and 16x8) share one
// stimulus stream and are checked every cycle against an array/bit model.
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1, ra2, ia, rad;
  logic        iv;

  logic [31:0] d1, d2, dd;
  logic        h1, h2, bd;
  logic [15:0] s_d1, s_d2, s_dd;
  logic        s_h1, s_h2, s_bd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  regfile_scoreboard dut_big (
    .clock(clock), .reset(reset),
    .write_enable(we), .write_address(wa), .write_data_in(wd),
    .read_address_1(ra1), .read_address_2(ra2),
    .data_out_1(d1), .data_out_2(d2), .hazard_1(h1), .hazard_2(h2),
    .issue_valid(iv), .issue_address(ia),
    .read_address_debug(rad), .data_out_debug(dd), .busy_out_debug(bd)
  );

  regfile_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut_small (
    .clock(clock), .reset(reset),
    .write_enable(we), .write_address(wa[2:0]), .write_data_in(wd[15:0]),
    .read_address_1(ra1[2:0]), .read_address_2(ra2[2:0]),
    .data_out_1(s_d1), .data_out_2(s_d2), .hazard_1(s_h1), .hazard_2(s_h2),
    .issue_valid(iv), .issue_address(ia[2:0]),
    .read_address_debug(rad[2:0]), .data_out_debug(s_dd), .busy_out_debug(s_bd)
  );

  // Model: index 0 is the 32x32 instance, index 1 the 16x8 instance.
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  logic [31:0] e_d1 [2], e_d2 [2], e_dd [2];
  bit          e_bd [2];

  function automatic logic [4:0] am(int k);
    return (k == 0) ? 5'd31 : 5'd7;
  endfunction

  function automatic logic [31:0] dm(int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic logic [31:0] m_rd(int k, logic [4:0] a_raw);
    logic [4:0] a;
    a = a_raw & am(k);
    if (a == 0) return 32'h0;
    if (we && ((wa & am(k)) == a)) return wd & dm(k);
    return m_mem[k][a];
  endfunction

  function automatic bit m_haz(int k, logic [4:0] a_raw);
    logic [4:0] a;
    a = a_raw & am(k);
    return m_busy[k][a] && (a != 0) && !(we && ((wa & am(k)) == a));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i]  = 32'h0;
        m_busy[k][i] = 1'b0;
      end
      e_d1[k] = 32'h0; e_d2[k] = 32'h0; e_dd[k] = 32'h0; e_bd[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    logic [4:0] wak, iak;
    for (int k = 0; k < 2; k++) begin
      e_d1[k] = m_rd(k, ra1);
      e_d2[k] = m_rd(k, ra2);
      e_dd[k] = m_rd(k, rad);
      wak = wa & am(k);
      iak = ia & am(k);
      if (we && wak != 0) m_mem[k][wak] = wd & dm(k);
      if (we) m_busy[k][wak] = 1'b0;
      if (iv) m_busy[k][iak] = 1'b1;
      m_busy[k][0] = 1'b0;
      e_bd[k] = m_busy[k][rad & am(k)];
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; iv = 1'b0; ia = '0;
  endtask

  // Compare process: all outputs against the model, away from the active edge.
  always @(negedge clock) begin
    check("big d1",  d1, e_d1[0]);
    check("big d2",  d2, e_d2[0]);
    check("big dd",  dd, e_dd[0]);
    check("big bd",  {31'h0, bd}, {31'h0, e_bd[0]});
    check("big h1",  {31'h0, h1}, {31'h0, m_haz(0, ra1)});
    check("big h2",  {31'h0, h2}, {31'h0, m_haz(0, ra2)});
    check("small d1", {16'h0, s_d1}, e_d1[1]);
    check("small d2", {16'h0, s_d2}, e_d2[1]);
    check("small dd", {16'h0, s_dd}, e_dd[1]);
    check("small bd", {31'h0, s_bd}, {31'h0, e_bd[1]});
    check("small h1", {31'h0, s_h1}, {31'h0, m_haz(1, ra1)});
    check("small h2", {31'h0, s_h2}, {31'h0, m_haz(1, ra2)});
  end

  initial begin
    reset = 1'b0;
    idle();
    ra1 = '0; ra2 = '0; rad = '0;
    model_reset();
    #12 reset = 1'b1;

    // Reset behaviour: load reg 5, mark it busy, then pulse reset between edges.
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    tick();
    idle(); iv = 1'b1; ia = 5'd5;
    tick();
    idle(); ra1 = 5'd5; ra2 = 5'd5; rad = 5'd5;
    tick();
    check("load d1", d1, 32'hDEAD_BEEF);
    check("load small d1", {16'h0, s_d1}, 32'h0000_BEEF);
    check("busy before reset", {31'h0, h1}, 32'h1);
    reset = 1'b0;
    #1;
    check("async rst d1", d1, 32'h0);
    check("async rst d2", d2, 32'h0);
    check("async rst dd", dd, 32'h0);
    check("async rst bd", {31'h0, bd}, 32'h0);
    #1 reset = 1'b1;
    model_reset();
    #1 check("post rst hazard", {31'h0, h1}, 32'h0);
    tick();
    check("post rst d1", d1, 32'h0);

    // Write with same-cycle read: bypass gives new data after one edge.
    we = 1'b1; wa = 5'd3; wd = 32'h1234_5678; ra1 = 5'd3;
    tick();
    check("bypass d1", d1, 32'h1234_5678);
    idle();
    tick();
    check("stored d1", d1, 32'h1234_5678);

    // Register 0 ignores writes and issues.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0;
    tick();
    check("zero d1", d1, 32'h0);
    check("zero d2", d2, 32'h0);
    idle(); iv = 1'b1; ia = 5'd0; rad = 5'd0;
    tick();
    idle();
    #1 check("zero hazard", {31'h0, h1}, 32'h0);
    check("zero busy", {31'h0, bd}, 32'h0);

    // Scoreboard: issue raises hazard next cycle; writeback clears it same cycle.
    iv = 1'b1; ia = 5'd7; ra1 = 5'd7;
    #1 check("issue cycle hazard", {31'h0, h1}, 32'h0);
    tick();
    idle();
    #1 check("hazard set", {31'h0, h1}, 32'h1);
    we = 1'b1; wa = 5'd7; wd = 32'h0000_00A5;
    #1 check("hazard cleared by wb", {31'h0, h1}, 32'h0);
    tick();
    check("wb data", d1, 32'h0000_00A5);
    idle();
    #1 check("hazard after wb", {31'h0, h1}, 32'h0);

    // Simultaneous issue and writeback of the same address: busy stays set.
    iv = 1'b1; ia = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'hCAFE_0009; rad = 5'd9;
    tick();
    check("set wins", {31'h0, bd}, 32'h1);
    idle(); ra1 = 5'd9;
    tick();
    check("set wins data", d1, 32'hCAFE_0009);
    check("set wins still busy", {31'h0, bd}, 32'h1);

    // Small instance: fill all 8 registers, read back with wrap from 7 to 0.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'hA000 + 32'(i) * 32'h0111;
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      ra1 = 5'(i); ra2 = 5'((i + 1) % 8); rad = 5'(7 - i);
      tick();
      check("small fill p1", {16'h0, s_d1},
            (i == 0) ? 32'h0 : 32'hA000 + 32'(i) * 32'h0111);
      check("small fill p2", {16'h0, s_d2},
            (i == 7) ? 32'h0 : 32'hA000 + 32'(i + 1) * 32'h0111);
      check("small fill dbg", {16'h0, s_dd},
            (i == 7) ? 32'h0 : 32'hA000 + 32'(7 - i) * 32'h0111);
    end

    // Randomised traffic, biased toward a few addresses to provoke collisions.
    for (int n = 0; n < 2000; n++) begin
      we  = ($urandom_range(0, 1) == 1);
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wd  = $urandom;
      iv  = ($urandom_range(0, 2) == 0);
      ia  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 1) == 0) ? ia : 5'($urandom);
      rad = 5'($urandom);
      tick();
    end

    idle();
    tick();
    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
